crc_block_engine: RTL
=====================

Name: crc_block_engine

Overview:
- Autonomous multi-mode CRC engine. Given a start pulse, it walks a block of SRAM words, folds one word per cycle into a selectable CRC, and returns the finalised CRC with a done pulse.
- Successor to the single-word CRC-16/CRC-32 datapath. Adds these features:
  - block length and base address
  - partial last word
  - four standard algorithms
  - chaining across jobs
- Sits between the SRAM read port and the host/control logic.

Parameters:
DATA_WIDTH, 32, SRAM word width; multiple of 8; BYTES = DATA_WIDTH/8
ADDR_WIDTH, 11, SRAM word-address width
CRC_WIDTH, 32, crc_out width; results narrower than 32 are right-aligned and zero-extended

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job request; honoured only when busy=0
crc_type  in  4  0000 CRC-16/CMS, 0001 CRC-16/CCITT-FALSE, 0010 CRC-32C, 1111 CRC-32; others reserved
chain  in  1  1 = seed from previous job's raw register instead of init
base_addr  in  ADDR_WIDTH  first word address
word_count  in  ADDR_WIDTH+1  words in job; 0 allowed
last_bytes  in  $clog2(BYTES)  valid bytes in final word; 0 = all BYTES
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
err  out  1  reserved mode or illegal chain; held until next accepted start
crc_out  out  CRC_WIDTH  finalised CRC; held until next accepted start
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_WIDTH  SRAM word address
mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en

Behaviour:
- Reset state: all outputs 0, FSM IDLE, raw register 0, "prev mode valid" flag 0.
- Reset applies asynchronously at any time, including mid-job:
  - busy, mem_rd_en and done drop immediately.
  - The aborted job never produces done.
- Algorithm table (poly / init / refin=refout / xorout):
  - CMS: 8005 / FFFF / no / 0000
  - CCITT-FALSE: 1021 / FFFF / no / 0000
  - CRC-32C: 1EDC6F41 / FFFFFFFF / yes / FFFFFFFF
  - CRC-32: 04C11DB7 / FFFFFFFF / yes / FFFFFFFF
- Byte order and bit order:
  - Bytes of a word are processed MSB-byte first.
  - refin reverses bit order within each byte.
  - refout reverses the whole CRC before xorout.
  - On the final word, only the upper last_bytes bytes are folded in; lower bytes are ignored.
- The datapath is a combinational unrolled fold of up to BYTES bytes per cycle.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches all inputs and seeds raw = chain ? raw : init. Then:
    - reserved crc_type → DONE with err=1, crc_out=0, no reads.
    - chain=1 with crc_type ≠ previous job's type, or no previous job → same as reserved.
    - word_count=0 → DONE.
    - otherwise → RUN.
  - RUN: mem_rd_en=1; mem_addr = base_addr + k for k = 0..N-1, one per cycle, wrapping modulo 2^ADDR_WIDTH. After issuing the last address → DRAIN.
  - The fold of word k happens in the cycle after its read, so folding overlaps RUN. DRAIN folds the last word only.
  - DONE: done=1 for one cycle; crc_out = refout/xorout-finalised raw register → IDLE.
- Timing, with start sampled at edge E0:
  - busy=1 for cycles 1..N+1.
  - mem_rd_en=1 in cycles 1..N.
  - done in cycle N+2.
  - Zero-length or error jobs: done in cycle 1, busy stays 0.
- start while busy=1 is ignored.
- start in the DONE cycle is ignored; the earliest restart is the cycle after done.
- The raw register and the previous-type record persist after done and are updated only by completed non-error jobs. These are the chaining seed.

Test Plan:
1. Setup for tests 1–3: mem[0x10..0x12] = 31323334, 35363738, 39000000 ("123456789"); base 0x10, count 3, last_bytes 1.
   - crc_type 1111 → crc_out CBF43926, err 0, done in cycle 5, mem_addr sequence 010, 011, 012.
2. Same data, crc_type 0000 → 0000AEE7; 0001 → 000029B1; 0010 → E3069283.
3. Chaining, crc_type 1111:
   - Job A: base 0x10, count 2, last_bytes 0.
   - Job B: chain 1, base 0x12, count 1, last_bytes 1 → crc_out CBF43926.
   - Job B with chain 1 but crc_type 0000 → err 1, crc_out 0, done in cycle 1.
4. Address wrap: the same three words at 0x7FF, 0x000, 0x001; base 0x7FF → mem_addr 7FF, 000, 001; crc_out CBF43926.
5. Edge cases:
   - count 0, crc_type 1111 → done in cycle 1, crc_out 00000000, no mem_rd_en.
   - crc_type 0101 → err 1, no reads.
   - Second start pulsed while busy → no effect on addresses or result.
6. Reset mid-job: rst_n=0 in cycle 2 of the test-1 job → busy, mem_rd_en and done go 0 at once; no done for that job. After rst_n=1, rerun test 1 → CBF43926. chain=1 after reset → err 1.

Source files
------------

// File: rtl/crc_block_engine.sv
// Block CRC engine: streams a run of SRAM words through one of four standard CRCs
// and returns the finalised value with a done pulse; supports chaining across jobs.
module crc_block_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CRC_WIDTH  = 32,
    localparam int BYTES     = DATA_WIDTH / 8,
    localparam int LBW       = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            crc_type,
    input  logic                  chain,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [LBW-1:0]        last_bytes,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // The raw register is always MSB-aligned in 32 bits; 16-bit CRCs live in the top half.
    function automatic logic mode_legal(input logic [3:0] t);
        return (t == 4'h0) || (t == 4'h1) || (t == 4'h2) || (t == 4'hF);
    endfunction

    // Both 32-bit algorithms are reflected, so width also selects refin/refout/xorout.
    function automatic logic mode_wide(input logic [3:0] t);
        return (t == 4'h2) || (t == 4'hF);
    endfunction

    function automatic logic [31:0] mode_poly(input logic [3:0] t);
        case (t)
            4'h0:    return 32'h8005_0000;
            4'h1:    return 32'h1021_0000;
            4'h2:    return 32'h1EDC_6F41;
            default: return 32'h04C1_1DB7;
        endcase
    endfunction

    function automatic logic [31:0] mode_init(input logic [3:0] t);
        return mode_wide(t) ? 32'hFFFF_FFFF : 32'hFFFF_0000;
    endfunction

    // Folds the upper nbytes bytes of a word, MSB byte first; refin feeds bit 0 of each byte first.
    function automatic logic [31:0] fold_word(input logic [31:0] seed,
                                              input logic [DATA_WIDTH-1:0] word,
                                              input logic [LBW:0] nbytes,
                                              input logic [31:0] poly,
                                              input logic refin);
        logic [31:0] r;
        logic [7:0]  d;
        logic        fb;
        r = seed;
        for (int b = 0; b < BYTES; b++) begin
            if (b < int'(nbytes)) begin
                d = word[DATA_WIDTH-1-8*b -: 8];
                for (int i = 0; i < 8; i++) begin
                    fb = r[31] ^ (refin ? d[i] : d[7-i]);
                    r  = {r[30:0], 1'b0} ^ (fb ? poly : 32'h0);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] finalize(input logic [31:0] r, input logic wide);
        logic [31:0] rev;
        for (int i = 0; i < 32; i++) rev[i] = r[31-i];
        return wide ? CRC_WIDTH'(rev ^ 32'hFFFF_FFFF) : CRC_WIDTH'({16'h0, r[31:16]});
    endfunction

    state_t                state;
    logic [31:0]           raw;
    logic [3:0]            type_q;
    logic [3:0]            prev_type;
    logic                  prev_valid;
    logic [LBW-1:0]        last_q;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  fold_v;
    logic [LBW:0]          last_n;
    logic [31:0]           raw_run;
    logic [31:0]           raw_last;
    logic [31:0]           seed;
    logic                  bad_req;

    assign last_n   = (last_q == '0) ? (LBW+1)'(BYTES) : {1'b0, last_q};
    assign raw_run  = fold_word(raw, mem_rdata, (LBW+1)'(BYTES), mode_poly(type_q), mode_wide(type_q));
    assign raw_last = fold_word(raw, mem_rdata, last_n, mode_poly(type_q), mode_wide(type_q));
    assign seed     = chain ? raw : mode_init(crc_type);
    assign bad_req  = !mode_legal(crc_type) ||
                      (chain && (!prev_valid || (crc_type != prev_type)));

    // Word k is read in one cycle and folded in the next, so the last fold lands in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            raw        <= '0;
            type_q     <= '0;
            prev_type  <= '0;
            prev_valid <= 1'b0;
            last_q     <= '0;
            remaining  <= '0;
            fold_v     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            crc_out    <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fold_v <= 1'b0;
                    if (start) begin
                        type_q  <= crc_type;
                        last_q  <= last_bytes;
                        err     <= 1'b0;
                        crc_out <= '0;
                        if (bad_req) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (word_count == '0) begin
                            raw        <= seed;
                            crc_out    <= finalize(seed, mode_wide(crc_type));
                            prev_type  <= crc_type;
                            prev_valid <= 1'b1;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            raw       <= seed;
                            remaining <= word_count - 1'b1;
                            mem_addr  <= base_addr;
                            mem_rd_en <= 1'b1;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fold_v) raw <= raw_run;
                    fold_v <= 1'b1;
                    if (remaining == '0) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        mem_addr  <= mem_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                DRAIN: begin
                    raw        <= raw_last;
                    crc_out    <= finalize(raw_last, mode_wide(type_q));
                    prev_type  <= type_q;
                    prev_valid <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    fold_v     <= 1'b0;
                    state      <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
